// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction queue between fetch and decode.
// Circular buffer of {pc, instr, fault} entries with valid/ready handshakes on both sides.
// The head entry is read straight from storage and masked to zero while the queue is empty.
// A flush empties the queue in one cycle and overrides any same-cycle handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                discard all entries; drops any offered fetch entry
//   fetch_valid/ready    enqueue handshake; fetch_ready = !full (registered state only)
//   fetch_pc/instr/fault payload of the offered entry
//   fetch_afull          occupancy >= AFULL_THRESH
//   dec_valid/ready      dequeue handshake; dec_valid = !empty
//   dec_pc/instr/fault   head entry, zero while empty
//   count                current occupancy
module fetch_buffer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr,
  input  logic                       fetch_fault,
  output logic                       fetch_afull,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_instr,
  output logic                       dec_fault,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullC = CntW'(AFULL_THRESH);

  // Storage is intentionally not reset; outputs are masked while empty.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        fault_mem [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  // Ready/valid come only from registered occupancy: a dequeue while full does not
  // free a slot until the following cycle.
  assign fetch_ready = !full;
  assign dec_valid   = !empty;
  assign fetch_afull = (count_q >= AfullC);
  assign count       = count_q;

  assign enq = fetch_valid && fetch_ready && !flush;
  assign deq = dec_valid && dec_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]    <= fetch_pc;
      instr_mem[wr_ptr_q] <= fetch_instr;
      fault_mem[wr_ptr_q] <= fetch_fault;
    end
  end

  // No empty-queue bypass: an entry becomes visible the cycle after it is written.
  always_comb begin
    dec_pc    = '0;
    dec_instr = '0;
    dec_fault = 1'b0;
    if (!empty) begin
      dec_pc    = pc_mem[rd_ptr_q];
      dec_instr = instr_mem[rd_ptr_q];
      dec_fault = fault_mem[rd_ptr_q];
    end
  end

`ifndef SYNTHESIS
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n) !(enq && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst_n) !(deq && empty));
  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DepthC);
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a queue-based reference model is compared with the
// DUT on every falling edge, plus directed scenarios with literal expectations.
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFULL = 6;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_instr;
  logic          fetch_fault;
  logic          fetch_afull;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic          dec_fault;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_buffer #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .fetch_afull (fetch_afull),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_fault   (dec_fault),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_deq;
      bit do_enq;
      ent_t e;
      do_deq = (mq.size() > 0) && dec_ready;
      do_enq = (mq.size() < DEPTH) && fetch_valid;
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        e.pc    = fetch_pc;
        e.instr = fetch_instr;
        e.fault = fetch_fault;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("m_count", 32'(count), 32'(sz));
    chk("m_dec_valid", 32'(dec_valid), 32'(sz > 0));
    chk("m_fetch_ready", 32'(fetch_ready), 32'(sz < DEPTH));
    chk("m_fetch_afull", 32'(fetch_afull), 32'(sz >= AFULL));
    chk("m_dec_pc", dec_pc, (sz > 0) ? mq[0].pc : 32'h0);
    chk("m_dec_instr", dec_instr, (sz > 0) ? mq[0].instr : 32'h0);
    chk("m_dec_fault", 32'(dec_fault), (sz > 0) ? 32'(mq[0].fault) : 32'h0);
  end

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic flt, input logic dr, input logic fl);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    fetch_fault = flt;
    dec_ready   = dr;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic flt);
    step(1'b1, pc, 32'h0000_0013, flt, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    fetch_instr = '0;
    fetch_fault = 1'b0;
    dec_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_fetch_afull", 32'(fetch_afull), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    rst_n = 1'b1;
    idle();

    // 1: three pushes with decode stalled
    push(32'h0, 1'b0);
    chk("t1_dec_valid", 32'(dec_valid), 32'd1);
    chk("t1_dec_pc", dec_pc, 32'h0);
    push(32'h4, 1'b0);
    push(32'h8, 1'b0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_dec_instr", dec_instr, 32'h0000_0013);
    do_flush();

    // 2: fill, hold a 9th offer, drain in order
    for (int i = 0; i < 8; i++) begin
      push(32'(i * 4), 1'b0);
      if (i == 4) chk("t2_afull_at5", 32'(fetch_afull), 32'd0);
      if (i == 5) chk("t2_afull_at6", 32'(fetch_afull), 32'd1);
    end
    chk("t2_full_ready", 32'(fetch_ready), 32'd0);
    chk("t2_full_count", 32'(count), 32'd8);
    push(32'h20, 1'b0);
    chk("t2_held_count", 32'(count), 32'd8);
    chk("t2_held_head", dec_pc, 32'h0);
    // Dequeue while full must not accept the held offer in the same cycle.
    step(1'b1, 32'h20, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    chk("t2_full_deq_count", 32'(count), 32'd7);
    chk("t2_head_after", dec_pc, 32'h4);
    for (int i = 1; i < 8; i++) begin
      chk("t2_drain_pc", dec_pc, 32'(i * 4));
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_empty_valid", 32'(dec_valid), 32'd0);

    // 3: steady stream, one in / one out per cycle
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h100 + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b1, 1'b0);
      chk("t3_count", 32'(count), 32'd1);
      chk("t3_head_pc", dec_pc, 32'h100 + 32'(i * 4));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 4: flush beats enqueue and dequeue
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i * 4), 1'b0);
    chk("t4_count5", 32'(count), 32'd5);
    step(1'b1, 32'hDEAD_0000, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
    chk("t4_flush_count", 32'(count), 32'd0);
    chk("t4_flush_valid", 32'(dec_valid), 32'd0);
    push(32'h500, 1'b0);
    chk("t4_next_pc", dec_pc, 32'h500);
    chk("t4_next_count", 32'(count), 32'd1);
    do_flush();

    // 5: fault entry between two normal ones
    push(32'h600, 1'b0);
    push(32'h604, 1'b1);
    push(32'h608, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_dec_fault", 32'(dec_fault), (i == 1) ? 32'd1 : 32'd0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("t5_empty", 32'(count), 32'd0);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) push(32'h700 + 32'(i * 4), 1'b0);
    chk("t6_count4", 32'(count), 32'd4);
    fetch_valid = 1'b1;
    dec_ready   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_valid", 32'(dec_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 4));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
